// File: rtl/pci_initiator_dataphase.sv
// pci_initiator_dataphase
//   PCI bus initiator sequencer: address phase, 1..4 data phases, optional
//   wait states, target disconnect, master abort on missing DEVSEL, and a
//   turnaround cycle before returning to idle.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, addr, cmd, count,   transaction request (sampled only when idle);
//   be_n                       count = data phases minus one, cmd[0]=1 write
//   wdata                      write word for the phase currently on the bus
//   TRDY, DEVSEL, STOP         active-low target responses
//   AD_in / AD_out, AD_oe      bus data sampled / driven, drive enable
//   FRAME, IRDY, CBE_out       active-low initiator controls, command/byte enables
//   busy, done, data_next,     status; done/data_next/master_abort/disconnect
//   master_abort, disconnect   are one-cycle pulses
//   rdata, rdata_valid         read word captured on a completing edge
module pci_initiator_dataphase (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [3:0]  cmd,
   input  logic [1:0]  count,
   input  logic [3:0]  be_n,
   input  logic [31:0] wdata,
   input  logic        TRDY,
   input  logic        DEVSEL,
   input  logic        STOP,
   input  logic [31:0] AD_in,
   output logic [31:0] AD_out,
   output logic        FRAME,
   output logic        IRDY,
   output logic [3:0]  CBE_out,
   output logic        AD_oe,
   output logic        busy,
   output logic        done,
   output logic        data_next,
   output logic        master_abort,
   output logic        disconnect,
   output logic [31:0] rdata,
   output logic        rdata_valid
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_DATA     = 3'd2,
      S_LASTIRDY = 3'd3,
      S_TURN     = 3'd4
   } state_t;

   state_t      state_r, state_nx;
   logic [31:0] addr_r, addr_nx;
   logic [3:0]  cmd_r, cmd_nx;
   logic [3:0]  be_r, be_nx;
   logic [1:0]  rem_r, rem_nx;
   logic [2:0]  dev_cnt_r, dev_cnt_nx;
   logic        dev_seen_r, dev_seen_nx;
   logic        phase_done_s, done_s, abort_s, disc_s;
   logic        frame_nx, irdy_nx, oe_nx;
   logic [3:0]  cbe_nx;
   logic        frame_r, irdy_r, oe_r, busy_r;
   logic [3:0]  cbe_r;
   logic        done_r, data_next_r, abort_r, disc_r, rvalid_r;
   logic [31:0] rdata_r;
   logic [31:0] ad_out_s;

   // Next-state and transaction bookkeeping.
   always_comb begin
      state_nx     = state_r;
      addr_nx      = addr_r;
      cmd_nx       = cmd_r;
      be_nx        = be_r;
      rem_nx       = rem_r;
      dev_cnt_nx   = dev_cnt_r;
      dev_seen_nx  = dev_seen_r;
      phase_done_s = 1'b0;
      done_s       = 1'b0;
      abort_s      = 1'b0;
      disc_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nx = S_ADDR;
               addr_nx  = addr;
               cmd_nx   = cmd;
               be_nx    = be_n;
               rem_nx   = count;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_ADDR: begin
            state_nx    = S_DATA;
            dev_cnt_nx  = 3'd0;
            dev_seen_nx = 1'b0;
         end
         S_DATA: begin
            // IRDY is low throughout DATA, so TRDY low alone completes a phase.
            phase_done_s = ~TRDY;
            if (~DEVSEL) begin
               dev_seen_nx = 1'b1;
            end else begin
               dev_seen_nx = dev_seen_r;
            end
            if (dev_cnt_r != 3'd7) begin
               dev_cnt_nx = dev_cnt_r + 3'd1;
            end else begin
               dev_cnt_nx = dev_cnt_r;
            end
            if (phase_done_s && (rem_r != 2'd0)) begin
               rem_nx = rem_r - 2'd1;
            end else begin
               rem_nx = rem_r;
            end
            // A completing edge is counted before STOP is acted upon.
            if (~STOP) begin
               disc_s = 1'b1;
               done_s = phase_done_s && (rem_r == 2'd0);
               if (rem_r == 2'd0) begin
                  state_nx = S_TURN;
               end else begin
                  state_nx = S_LASTIRDY;
               end
            end else if (phase_done_s && (rem_r == 2'd0)) begin
               done_s   = 1'b1;
               state_nx = S_TURN;
            end else if (~dev_seen_r && DEVSEL && (dev_cnt_r == 3'd4)) begin
               // Fifth DATA edge without DEVSEL: nobody claimed the cycle.
               abort_s = 1'b1;
               if (rem_r == 2'd0) begin
                  state_nx = S_TURN;
               end else begin
                  state_nx = S_LASTIRDY;
               end
            end else begin
               state_nx = S_DATA;
            end
         end
         S_LASTIRDY: state_nx = S_TURN;
         S_TURN:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Bus control values for the upcoming state, so the pins come from flops.
   always_comb begin
      frame_nx = 1'b1;
      irdy_nx  = 1'b1;
      cbe_nx   = 4'hF;
      oe_nx    = 1'b0;
      case (state_nx)
         S_ADDR: begin
            frame_nx = 1'b0;
            cbe_nx   = cmd_nx;
            oe_nx    = 1'b1;
         end
         S_DATA: begin
            frame_nx = (rem_nx == 2'd0);
            irdy_nx  = 1'b0;
            cbe_nx   = be_nx;
            oe_nx    = cmd_nx[0];
         end
         S_LASTIRDY: begin
            irdy_nx = 1'b0;
            cbe_nx  = be_nx;
            oe_nx   = cmd_nx[0];
         end
         default: begin
            frame_nx = 1'b1;
            irdy_nx  = 1'b1;
            cbe_nx   = 4'hF;
            oe_nx    = 1'b0;
         end
      endcase
   end

   // AD mux: latched address, then the live write word while data is owed.
   always_comb begin
      ad_out_s = 32'd0;
      if (state_r == S_ADDR) begin
         ad_out_s = addr_r;
      end else if (((state_r == S_DATA) || (state_r == S_LASTIRDY)) && cmd_r[0]) begin
         ad_out_s = wdata;
      end else begin
         ad_out_s = 32'd0;
      end
   end

   // State, latched request, registered bus controls and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         addr_r      <= 32'd0;
         cmd_r       <= 4'd0;
         be_r        <= 4'hF;
         rem_r       <= 2'd0;
         dev_cnt_r   <= 3'd0;
         dev_seen_r  <= 1'b0;
         frame_r     <= 1'b1;
         irdy_r      <= 1'b1;
         cbe_r       <= 4'hF;
         oe_r        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         data_next_r <= 1'b0;
         abort_r     <= 1'b0;
         disc_r      <= 1'b0;
         rdata_r     <= 32'd0;
         rvalid_r    <= 1'b0;
      end else begin
         state_r     <= state_nx;
         addr_r      <= addr_nx;
         cmd_r       <= cmd_nx;
         be_r        <= be_nx;
         rem_r       <= rem_nx;
         dev_cnt_r   <= dev_cnt_nx;
         dev_seen_r  <= dev_seen_nx;
         frame_r     <= frame_nx;
         irdy_r      <= irdy_nx;
         cbe_r       <= cbe_nx;
         oe_r        <= oe_nx;
         busy_r      <= (state_nx != S_IDLE);
         done_r      <= done_s;
         data_next_r <= phase_done_s;
         abort_r     <= abort_s;
         disc_r      <= disc_s;
         if (phase_done_s && ~cmd_r[0]) begin
            rdata_r  <= AD_in;
            rvalid_r <= 1'b1;
         end else begin
            rdata_r  <= rdata_r;
            rvalid_r <= 1'b0;
         end
      end
   end

   assign AD_out       = ad_out_s;
   assign FRAME        = frame_r;
   assign IRDY         = irdy_r;
   assign CBE_out      = cbe_r;
   assign AD_oe        = oe_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign data_next    = data_next_r;
   assign master_abort = abort_r;
   assign disconnect   = disc_r;
   assign rdata        = rdata_r;
   assign rdata_valid  = rvalid_r;

endmodule
